// File: rtl/fifo_v4_if.sv
// rtl/fifo_v4_if.sv - producer/consumer handshake, flush and status bundle for fifo_v4
interface fifo_v4_if #(
  parameter type dtype = logic [31:0],
  parameter int  CNT_W = 4
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  dtype             data_i;
  logic             valid_o;
  logic             ready_i;
  dtype             data_o;
  logic [CNT_W-1:0] usage_o;
  logic             full_o;
  logic             empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;

  modport master (
    output flush_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, usage_o, full_o, empty_o, almost_full_o, almost_empty_o
  );

  modport slave (
    input  flush_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, usage_o, full_o, empty_o, almost_full_o, almost_empty_o
  );
endinterface

// File: rtl/fifo_v4.sv
// rtl/fifo_v4.sv - synchronous valid/ready FIFO with occupancy, thresholds and optional fall-through
module fifo_v4 #(
  parameter bit  FALL_THROUGH    = 1'b0,
  parameter int  DATA_WIDTH      = 32,
  parameter int  DEPTH           = 8,
  parameter int  ALMOST_FULL_TH  = DEPTH - 1,
  parameter int  ALMOST_EMPTY_TH = 1,
  parameter type dtype           = logic [DATA_WIDTH-1:0]
) (
  input logic      clk_i,
  input logic      rst_i,
  fifo_v4_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("fifo_v4: DEPTH must be at least 1");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("fifo_v4: ALMOST_FULL_TH must lie in 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_v4: ALMOST_EMPTY_TH must lie in 0..DEPTH-1");
  end

  dtype              r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_usage;

  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;

  assign w_full  = (r_usage == CNT_W'(DEPTH));
  assign w_empty = (r_usage == '0);

  // ready_o depends only on stored state, never on ready_i
  assign w_ready  = ~w_full & ~bus.flush_i & ~rst_i;
  assign w_valid  = (~w_empty | (FALL_THROUGH & bus.valid_i)) & ~bus.flush_i & ~rst_i;
  assign w_push   = bus.valid_i & w_ready;
  assign w_pop    = w_valid & bus.ready_i;
  assign w_bypass = FALL_THROUGH & w_empty & w_push & w_pop;

  // explicit wrap keeps non-power-of-two depths inside the array
  assign w_rd_ptr_nxt = (r_rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + ADDR_W'(1);
  assign w_wr_ptr_nxt = (r_wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_usage  <= '0;
    end else if (!w_bypass) begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push && !w_pop) begin
        r_usage <= r_usage + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_usage <= r_usage - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !w_bypass) r_mem[r_wr_ptr] <= bus.data_i;
  end

  assign bus.ready_o        = w_ready;
  assign bus.valid_o        = w_valid;
  assign bus.data_o         = (FALL_THROUGH && w_empty) ? bus.data_i : r_mem[r_rd_ptr];
  assign bus.usage_o        = r_usage;
  assign bus.full_o         = w_full;
  assign bus.empty_o        = w_empty;
  assign bus.almost_full_o  = (r_usage >= CNT_W'(ALMOST_FULL_TH));
  assign bus.almost_empty_o = (r_usage <= CNT_W'(ALMOST_EMPTY_TH));

  a_hold_payload: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.valid_i && !w_ready && !bus.flush_i) |=> (bus.valid_i && $stable(bus.data_i)))
    else $error("fifo_v4: valid_i dropped or data_i changed before ready_o");

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && w_full))
    else $error("fifo_v4: push while full");
endmodule
